// File: rtl/dequantizer_stream.sv
// -----------------------------------------------------------------------------
// dequantizer_stream
//   Streaming coefficient dequantizer. Every coefficient of a raster-ordered
//   BLOCK_SIZE x BLOCK_SIZE block is shifted left by a per-position amount
//   taken from one of NUM_TABLES programmable shift tables. The table is
//   chosen once per block, on its first coefficient. There is a 2-stage
//   valid/ready pipeline: stage 1 holds the coefficient and the shift looked
//   up for it, and stage 2 holds the shifted result.
//
//   Optional feature macro: DEQ_SATURATE_EN
//     defined   : a result that overflows is clamped to the signed range
//     undefined : a result is truncated to COEFF_WIDTH bits (wraps)
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  input handshake
//   in_coeff           signed quantized coefficient
//   in_tsel            table select, sampled on idx 0 only
//   in_last            framing marker from the source
//   out_valid/ready    output handshake
//   out_coeff          dequantized coefficient
//   out_last           emitted coefficient had idx N-1
//   tbl_we/sel/addr/data  shift table write port
//   sync_err           sticky framing error
// -----------------------------------------------------------------------------
module dequantizer_stream #(
   parameter int BLOCK_SIZE  = 8,
   parameter int COEFF_WIDTH = 54,
   parameter int SHIFT_WIDTH = 3,
   parameter int NUM_TABLES  = 2,
   parameter int TSEL_W      = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1,
   parameter int ADDR_W      = $clog2(BLOCK_SIZE*BLOCK_SIZE)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [COEFF_WIDTH-1:0] in_coeff,
   input  logic [TSEL_W-1:0]      in_tsel,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [COEFF_WIDTH-1:0] out_coeff,
   output logic                   out_last,
   input  logic                   tbl_we,
   input  logic [TSEL_W-1:0]      tbl_sel,
   input  logic [ADDR_W-1:0]      tbl_addr,
   input  logic [SHIFT_WIDTH-1:0] tbl_data,
   output logic                   sync_err
);

   localparam int N = BLOCK_SIZE*BLOCK_SIZE;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N-1);

   logic [SHIFT_WIDTH-1:0] r_tbl [NUM_TABLES][N];
   logic [ADDR_W-1:0]      r_idx;
   logic [TSEL_W-1:0]      r_tsel;
   logic                   r_rdy;
   logic                   r_sync_err;

   logic                   r_s1_vld;
   logic [COEFF_WIDTH-1:0] r_s1_coeff;
   logic [SHIFT_WIDTH-1:0] r_s1_shift;
   logic                   r_s1_last;

   logic                   r_s2_vld;
   logic [COEFF_WIDTH-1:0] r_s2_coeff;
   logic                   r_s2_last;

   logic                   w_s2_adv;
   logic                   w_acc;
   logic [TSEL_W-1:0]      w_tsel;
   logic [SHIFT_WIDTH-1:0] w_shift;
   logic [COEFF_WIDTH-1:0] w_res;

   // Stage 2 can take new data when it is empty or it is draining this cycle.
   // Stage 1 can then always move on, so input is refused only when both
   // stages are full and the output is blocked.
   assign w_s2_adv = !r_s2_vld || out_ready;
   assign in_ready = r_rdy && !(r_s1_vld && r_s2_vld && !out_ready);
   assign w_acc    = in_valid && in_ready;

   // The table is chosen live on idx 0 and held for the rest of the block.
   // An out-of-range select falls back to table 0.
   always_comb begin
      w_tsel = (r_idx == '0) ? in_tsel : r_tsel;
      if (int'(w_tsel) >= NUM_TABLES) w_tsel = '0;
   end

   // The table read comes from registered state. A write in the same cycle
   // therefore cannot be seen until the next lookup.
   assign w_shift = r_tbl[w_tsel][r_idx];

`ifdef DEQ_SATURATE_EN
   localparam int MAXSH = (1 << SHIFT_WIDTH) - 1;
   localparam int WW    = COEFF_WIDTH + MAXSH;
   logic [WW-1:0]    w_ext;
   logic [WW-1:0]    w_shl;
   logic [MAXSH:0]   w_hi;
   // The shift is done at full width. The result fits in COEFF_WIDTH only
   // if every bit above the new sign bit is a copy of that sign bit.
   always_comb begin
      w_ext = {{MAXSH{r_s1_coeff[COEFF_WIDTH-1]}}, r_s1_coeff};
      w_shl = w_ext << r_s1_shift;
      w_hi  = w_shl[WW-1:COEFF_WIDTH-1];
      w_res = w_shl[COEFF_WIDTH-1:0];
      if (!((&w_hi) || !(|w_hi)))
         w_res = w_shl[WW-1] ? {1'b1, {(COEFF_WIDTH-1){1'b0}}}
                             : {1'b0, {(COEFF_WIDTH-1){1'b1}}};
   end
`else
   assign w_res = r_s1_coeff << r_s1_shift;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int t = 0; t < NUM_TABLES; t++)
            for (int a = 0; a < N; a++)
               r_tbl[t][a] <= '0;
      end else if (tbl_we && (int'(tbl_sel) < NUM_TABLES)) begin
         r_tbl[tbl_sel][tbl_addr] <= tbl_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdy      <= 1'b0;
         r_idx      <= '0;
         r_tsel     <= '0;
         r_sync_err <= 1'b0;
         r_s1_vld   <= 1'b0;
         r_s1_coeff <= '0;
         r_s1_shift <= '0;
         r_s1_last  <= 1'b0;
         r_s2_vld   <= 1'b0;
         r_s2_coeff <= '0;
         r_s2_last  <= 1'b0;
      end else begin
         r_rdy <= 1'b1;
         if (w_acc) begin
            r_s1_vld   <= 1'b1;
            r_s1_coeff <= in_coeff;
            r_s1_shift <= w_shift;
            r_s1_last  <= (r_idx == LAST_IDX);
            if (r_idx == '0) r_tsel <= w_tsel;
            if (in_last != (r_idx == LAST_IDX)) r_sync_err <= 1'b1;
            // A source-signalled end of block always resynchronises to idx 0.
            r_idx <= (in_last || r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
         end else if (w_s2_adv) begin
            r_s1_vld <= 1'b0;
         end
         if (w_s2_adv) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
               r_s2_coeff <= w_res;
               r_s2_last  <= r_s1_last;
            end
         end
      end
   end

   assign out_valid = r_s2_vld;
   assign out_coeff = r_s2_coeff;
   assign out_last  = r_s2_last;
   assign sync_err  = r_sync_err;

endmodule

// File: tb/tb_dequantizer_stream.sv
// -----------------------------------------------------------------------------
// tb_dequantizer_stream
//   Directed bench for dequantizer_stream using the default parameters
//   (8x8 blocks, 54-bit coefficients, 3-bit shifts, 2 tables). Every expected
//   output is a hand-computed constant. A negedge monitor pops expected
//   {last, coeff} pairs in order as outputs are emitted.
// -----------------------------------------------------------------------------
module tb_dequantizer_stream;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [53:0] in_coeff = '0;
   logic        in_tsel = 1'b0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [53:0] out_coeff;
   logic        out_last;
   logic        tbl_we = 1'b0;
   logic        tbl_sel = 1'b0;
   logic [5:0]  tbl_addr = '0;
   logic [2:0]  tbl_data = '0;
   logic        sync_err;

   int n_chk = 0;
   int n_err = 0;
   int n_out = 0;
   logic [54:0] expq[$];

   dequantizer_stream dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_coeff(in_coeff),
      .in_tsel(in_tsel), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_coeff(out_coeff),
      .out_last(out_last),
      .tbl_we(tbl_we), .tbl_sel(tbl_sel), .tbl_addr(tbl_addr),
      .tbl_data(tbl_data), .sync_err(sync_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Output scoreboard: sampled on the negedge, where handshake signals are stable.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         n_out++;
         if (expq.size() == 0) begin
            check("extra_out", 64'(out_coeff), 64'hDEAD);
         end else begin
            logic [54:0] e;
            e = expq.pop_front();
            check("out_coeff", 64'(out_coeff), 64'(e[53:0]));
            check("out_last", 64'(out_last), 64'(e[54]));
         end
      end
   end

   task automatic send(input logic [53:0] c, input logic t, input logic l,
                       input logic [53:0] e, input logic el);
      in_valid = 1'b1; in_coeff = c; in_tsel = t; in_last = l;
      for (int k = 0; ; k++) begin
         @(negedge clk);
         if (in_ready) break;
         if (k == 200) begin
            check("send_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
         end
      end
      expq.push_back({el, e});
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic wr(input logic s, input logic [5:0] a, input logic [2:0] d);
      tbl_we = 1'b1; tbl_sel = s; tbl_addr = a; tbl_data = d;
      @(posedge clk); #1;
      tbl_we = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 100 && expq.size() != 0; k++) @(posedge clk);
      #1;
      check("drain", 64'(expq.size()), 64'd0);
   endtask

   // One full block: idx 0/1 take the given coefficients, idx 2 carries 1,
   // and every other index carries 7 (those table entries stay 0). in_tsel is
   // inverted after idx 0 to show that only the first select counts.
   task automatic run_block(input logic t, input logic [53:0] c0, input logic [53:0] e0,
                            input logic [53:0] c1, input logic [53:0] e1,
                            input logic [53:0] e2, input bit wr2);
      for (int i = 0; i < 64; i++) begin
         logic [53:0] c, e;
         c = (i == 0) ? c0 : (i == 1) ? c1 : (i == 2) ? 54'd1 : 54'd7;
         e = (i == 0) ? e0 : (i == 1) ? e1 : (i == 2) ? e2 : 54'd7;
         if (wr2 && i == 2) begin
            tbl_we = 1'b1; tbl_sel = 1'b0; tbl_addr = 6'd2; tbl_data = 3'd1;
         end
         send(c, (i == 0) ? t : ~t, i == 63, e, i == 63);
         tbl_we = 1'b0;
      end
      drain();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      expq.delete();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_coeff", 64'(out_coeff), 64'd0);
      check("rst_out_last", 64'(out_last), 64'd0);
      check("rst_sync_err", 64'(sync_err), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rel_in_ready", 64'(in_ready), 64'd1);
   endtask

   initial begin
      int base;
      logic [53:0] p52, m52, esat_p, esat_m;
      p52 = 54'd1 << 52;
      m52 = -(54'd1 << 52);
`ifdef DEQ_SATURATE_EN
      esat_p = (54'd1 << 53) - 54'd1;
      esat_m = -(54'd1 << 53);
`else
      esat_p = '0;
      esat_m = '0;
`endif
      @(posedge clk); #1;
      do_reset();

      // Identity stream 0..63, with a latency probe on the first coefficient.
      send(54'd0, 1'b0, 1'b0, 54'd0, 1'b0);
      @(negedge clk);
      check("lat_cycle1_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      check("lat_cycle2_valid", 64'(out_valid), 64'd1);
      check("lat_cycle2_coeff", 64'(out_coeff), 64'd0);
      for (int i = 1; i < 64; i++) send(54'(i), 1'b0, i == 63, 54'(i), i == 63);
      drain();
      check("identity_count", 64'(n_out), 64'd64);
      check("identity_sync", 64'(sync_err), 64'd0);

      // Output stalled for 5 cycles while input is held valid.
      base = n_out;
      fork
         for (int i = 0; i < 64; i++) send(54'(100 + i), 1'b0, i == 63, 54'(100 + i), i == 63);
         begin
            repeat (20) @(posedge clk);
            #1 out_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               check("stall_in_ready", 64'(in_ready), 64'd0);
            end
            @(posedge clk); #1 out_ready = 1'b1;
            @(negedge clk);
            check("unstall_in_ready", 64'(in_ready), 64'd1);
         end
      join
      drain();
      check("stall_count", 64'(n_out - base), 64'd64);

      // Tables: table1[0]=1, table1[1]=2, table0[0]=3.
      wr(1'b0, 6'd0, 3'd3);
      wr(1'b1, 6'd0, 3'd1);
      wr(1'b1, 6'd1, 3'd2);
      run_block(1'b1, -54'sd5, -54'sd10, 54'd1, 54'd4, 54'd1, 1'b0);
      // table0[2] written during the idx 2 lookup: old value (0) applies.
      run_block(1'b0, -54'sd5, -54'sd40, 54'd1, 54'd1, 54'd1, 1'b1);

      // Overflow on shift 2; table0[2]=1 is now visible.
      wr(1'b0, 6'd0, 3'd2);
      wr(1'b0, 6'd1, 3'd2);
      run_block(1'b0, p52, esat_p, m52, esat_m, 54'd2, 1'b0);
      check("pre_sync_err", 64'(sync_err), 64'd0);

      // Early in_last at idx 10 on table 1.
      for (int i = 0; i <= 10; i++)
         send(54'd3, 1'b1, i == 10, (i == 0) ? 54'd6 : (i == 1) ? 54'd12 : 54'd3, 1'b0);
      drain();
      check("sync_err_set", 64'(sync_err), 64'd1);
      // New block starts at idx 0, table1[0]=1 applies, up to idx 29.
      for (int i = 0; i < 30; i++)
         send(54'd3, 1'b1, 1'b0, (i == 0) ? 54'd6 : (i == 1) ? 54'd12 : 54'd3, 1'b0);
      check("sync_err_sticky", 64'(sync_err), 64'd1);

      // Reset mid-block at idx 30 with data in flight.
      do_reset();
      run_block(1'b1, -54'sd5, -54'sd5, 54'd1, 54'd1, 54'd1, 1'b0);
      check("post_rst_sync", 64'(sync_err), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/dequantizer_stream.md
DEQUANTIZER_STREAM -- requirements
Module: dequantizer_stream

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 8: block edge; N = BLOCK_SIZE*BLOCK_SIZE coefficients per block.
REQ-002 SHALL have parameter COEFF_WIDTH, default 54: signed coefficient width on input and output.
REQ-003 SHALL have parameter SHIFT_WIDTH, default 3: unsigned left-shift amount per table entry.
REQ-004 SHALL have parameter NUM_TABLES, default 2: number of shift tables (e.g. luma, chroma); TSEL_W = max(1, clog2(NUM_TABLES)).
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-006 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- in_valid  in  1  input coefficient valid.
- in_ready  out  1  block can accept an input coefficient.
- in_coeff  in  COEFF_WIDTH  signed quantized coefficient, raster order.
- in_tsel  in  TSEL_W  table select; sampled on the first coefficient of each block only.
- in_last  in  1  last coefficient of block.
- out_valid  out  1  output coefficient valid.
- out_ready  in  1  downstream accepts.
- out_coeff  out  COEFF_WIDTH  dequantized coefficient.
- out_last  out  1  marks index N-1 of the internal counter.
- tbl_we  in  1  table write enable.
- tbl_sel  in  TSEL_W  table written.
- tbl_addr  in  clog2(N)  raster index written.
- tbl_data  in  SHIFT_WIDTH  shift value written.
- sync_err  out  1  sticky framing error.

Function
REQ-007 SHALL accept a coefficient on the rising edge of clk when in_valid and in_ready are both 1, and SHALL emit it on the rising edge of clk when out_valid and out_ready are both 1.
REQ-008 SHALL compute out_coeff = in_coeff arithmetically shifted left by table[tsel][idx], where idx is the internal raster counter and tsel is latched at idx=0.
REQ-009 SHALL use a 2-stage pipeline: stage 1 registers coeff, idx and the looked-up shift; stage 2 registers the shifted result; latency SHALL be 2 cycles; throughput SHALL be 1 coefficient per cycle while out_ready=1.
REQ-010 SHALL stall both stages when stage 2 holds data and out_ready=0, with in_ready = !(stage1 full and stage2 full and !out_ready); no coefficient SHALL be dropped or duplicated.
REQ-011 SHALL increment idx on each accepted input and wrap it from N-1 to 0; out_last SHALL be 1 exactly when the emitted coefficient had idx N-1.
REQ-012 SHALL set sync_err (sticky until reset) when in_last=1 at idx!=N-1 or in_last=0 at idx=N-1; on in_last=1 idx SHALL reset to 0 regardless.
REQ-013 SHALL make a table write visible to lookups from the next cycle; a same-cycle write and lookup of the same entry SHALL return the old value.
REQ-014 SHALL ignore a write with tbl_sel >= NUM_TABLES, and SHALL treat in_tsel >= NUM_TABLES as table 0.

Reset
REQ-015 SHALL, on rst_n low, clear out_valid, out_coeff, out_last, sync_err, idx and both pipeline stages to 0, and SHALL set in_ready to 1 one cycle after rst_n is released.
REQ-016 SHALL reset all table entries to 0 (identity), and SHALL discard an in-flight block on mid-block reset; the next accepted coefficient SHALL be idx 0.

Configuration
REQ-017 SHALL support macro DEQ_SATURATE_EN: when defined, a result that overflows COEFF_WIDTH SHALL clamp to 2^(COEFF_WIDTH-1)-1 or -2^(COEFF_WIDTH-1).
REQ-018 SHALL, when DEQ_SATURATE_EN is undefined, truncate a result to its low COEFF_WIDTH bits (two's-complement wrap), with no extra latency in either mode.

Verification
REQ-019 SHALL have a bench cover, per line: stimulus -> required response.
- Reset tables, stream 64 coeffs 0..63, out_ready=1 -> outputs 0..63 two cycles after each input; out_last on the 64th only; sync_err=0.
- Write table0[0]=3, table1[0]=1; block with in_tsel=1, coeff[0]=-5 -> out -10; next block in_tsel=0, coeff[0]=-5 -> out -40.
- COEFF_WIDTH=54, shift 2, coeff 2^52 -> 2^53-1 with DEQ_SATURATE_EN, 0 without; coeff -2^52 -> -2^53 and 0 respectively.
- out_ready low 5 cycles mid-stream with in_valid held -> in_ready low after 2 coefficients buffered; after release all 64 outputs are in order with no loss.
- in_last=1 at idx 10 -> sync_err=1 and stays 1; next accepted coefficient uses idx 0 (table[0] shift).
- rst_n low at idx 30 -> out_valid=0 immediately; after release a fresh block is processed from idx 0 with identity tables.
